// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported synchronous memory between the instruction-fetch
// port (IF) and the load/store data port (DM) of the pipelined core.
// At most one memory command is issued per cycle. Read data comes back from
// the memory one cycle after the command and is routed to whichever port
// issued that read.
//
// Arbitration:
//   - DM normally wins.
//   - IF wins whenever the starvation counter has reached STARVE_LIMIT.
//   - A halted core (halt = 1) gets no fetch grants; DM traffic is unaffected.
//
// Handshake: a requester raises req with a stable payload and holds both
// until it sees gnt high in the same cycle. A grant is combinational and
// means the command is presented to the memory in that cycle. A read grant
// is followed by rvalid/rdata exactly one cycle later; a write grant
// completes in its own cycle and produces no rvalid.
//
// Ports:
//   clk1, rst_n                 clock, asynchronous active-low reset
//   halt                        core halted: block fetch grants
//   if_req/if_addr              fetch request and word address
//   if_gnt/if_rvalid/if_rdata   fetch grant and returned data
//   dm_req/dm_we/dm_addr/dm_wdata  load/store request
//   dm_gnt/dm_rvalid/dm_rdata   data grant and returned load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory command/data port
//   conflict_cnt                saturating count of cycles both ports wanted
//                               the memory
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              halt,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    // Which port owns the read data returning this cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_DM = 2'd2
    } rd_state_e;

    rd_state_e        state_q, state_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;

    logic if_eff;
    logic starve_hit;
    logic if_win;
    logic dm_win;

    // -------------------------------------------------------------------------
    // Arbitration. Grants are qualified by rst_n so that nothing reaches the
    // memory while reset is held, even though the requests themselves are
    // free to be high.
    // -------------------------------------------------------------------------
    always_comb begin
        if_eff     = if_req & ~halt;
        starve_hit = (starve_q == STARVE_MAX);
        if_win     = rst_n & if_eff & (starve_hit | ~dm_req);
        dm_win     = rst_n & dm_req & ~if_win;
    end

    assign if_gnt = if_win;
    assign dm_gnt = dm_win;

    // -------------------------------------------------------------------------
    // Memory command drive. The address follows the winner; write data is
    // only meaningful for DM and is zeroed otherwise.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en    = if_win | dm_win;
        mem_we    = dm_win & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_win) begin
            mem_addr = if_addr;
        end else if (dm_win) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read-tracking FSM: the state simply remembers who issued a read in the
    // previous cycle, so every state can go to every other state.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = ST_IDLE;
        if (if_win) begin
            state_d = ST_RD_IF;
        end else if (dm_win && !dm_we) begin
            state_d = ST_RD_DM;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign if_rvalid = (state_q == ST_RD_IF);
    assign dm_rvalid = (state_q == ST_RD_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    // -------------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles an unhalted fetch was
    // refused. A halted core is not being starved, so halt clears it.
    // -------------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (if_win || halt) begin
            starve_d = '0;
        end else if (if_req && !starve_hit) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // -------------------------------------------------------------------------
    // Conflict counter: cycles where both ports competed; sticks at all-ones.
    // -------------------------------------------------------------------------
    always_comb begin
        conflict_d = conflict_q;
        if (if_eff && dm_req && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter (built with CNT_W = 4 so saturation is reachable).
// A memory model sits on the mem_* port. A reference predictor evaluates the
// arbitration rules every cycle, checks grants and the memory command, and
// pushes expected read data into per-port queues tagged with the cycle the
// data is due; an independent monitor pops and compares on every rvalid.
// Directed sequences cover the listed scenarios, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  logic              halt = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;

  logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] if_rdata, dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // ---------------- memory environment ----------------
  function automatic logic [DATA_W-1:0] init_val(int i);
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  logic [DATA_W-1:0] env_mem [1024];
  bit env_init = 1'b0;
  always @(posedge clk1) begin
    if (!env_init) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= init_val(i);
      env_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    fails++;
    $display("FAIL %s: event seen/missed in cycle %0d (t=%0t)", name, cyc, $time);
  endtask

  // ---------------- reference predictor ----------------
  logic [DATA_W-1:0] ref_mem [1024];
  bit                ref_init = 1'b0;
  logic [DATA_W-1:0] if_exp_q[$];
  int                if_due_q[$];
  logic [DATA_W-1:0] dm_exp_q[$];
  int                dm_due_q[$];
  int                m_starve = 0;
  int                m_conf = 0;
  bit                last_if_gnt = 1'b0;
  bit                last_dm_gnt = 1'b0;

  always @(negedge clk1) begin
    bit eff, e_if, e_dm;
    if (!ref_init) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_dm_gnt", 32'(dm_gnt), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_conflict", 32'(conflict_cnt), 0);
      m_starve = 0;
      m_conf = 0;
      if_exp_q.delete(); if_due_q.delete();
      dm_exp_q.delete(); dm_due_q.delete();
      last_if_gnt = 1'b0;
      last_dm_gnt = 1'b0;
    end else begin
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
      eff  = if_req && !halt;
      e_if = eff && (m_starve == STARVE_LIMIT || !dm_req);
      e_dm = dm_req && !e_if;
      chk("if_gnt", 32'(if_gnt), 32'(e_if));
      chk("dm_gnt", 32'(dm_gnt), 32'(e_dm));
      chk("mem_en", 32'(mem_en), 32'(e_if || e_dm));
      chk("mem_we", 32'(mem_we), 32'(e_dm && dm_we));
      chk("mem_addr", 32'(mem_addr), e_if ? 32'(if_addr) : (e_dm ? 32'(dm_addr) : 32'd0));
      chk("mem_wdata", mem_wdata, e_dm ? dm_wdata : 32'd0);
      if (e_if) begin
        if_exp_q.push_back(ref_mem[if_addr]);
        if_due_q.push_back(cyc + 1);
      end
      if (e_dm && !dm_we) begin
        dm_exp_q.push_back(ref_mem[dm_addr]);
        dm_due_q.push_back(cyc + 1);
      end
      if (e_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
      if (e_if || halt) m_starve = 0;
      else if (if_req && m_starve < STARVE_LIMIT) m_starve++;
      if (eff && dm_req && m_conf < CNT_MAX) m_conf++;
      last_if_gnt = if_gnt;
      last_dm_gnt = dm_gnt;
    end
  end

  // ---------------- read-data monitor ----------------
  always @(negedge clk1) begin
    if (rst_n) begin
      while (if_due_q.size() > 0 && if_due_q[0] < cyc) begin
        fail_now("if_rvalid_missing");
        void'(if_exp_q.pop_front()); void'(if_due_q.pop_front());
      end
      while (dm_due_q.size() > 0 && dm_due_q[0] < cyc) begin
        fail_now("dm_rvalid_missing");
        void'(dm_exp_q.pop_front()); void'(dm_due_q.pop_front());
      end
      if (if_rvalid) begin
        if (if_due_q.size() == 0 || if_due_q[0] != cyc) fail_now("if_rvalid_unexpected");
        else begin
          chk("if_rdata", if_rdata, if_exp_q.pop_front());
          void'(if_due_q.pop_front());
        end
      end else chk("if_rdata_idle", if_rdata, 0);
      if (dm_rvalid) begin
        if (dm_due_q.size() == 0 || dm_due_q[0] != cyc) fail_now("dm_rvalid_unexpected");
        else begin
          chk("dm_rdata", dm_rdata, dm_exp_q.pop_front());
          void'(dm_due_q.pop_front());
        end
      end else chk("dm_rdata_idle", dm_rdata, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle_inputs();
    halt = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_random(int n);
    repeat (n) begin
      tick();
      if (!if_req || last_if_gnt) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = ADDR_W'($urandom_range(0, 31));
      end
      if (!dm_req || last_dm_gnt) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = ADDR_W'($urandom_range(0, 31));
        dm_wdata = $urandom;
      end
      halt = ($urandom_range(0, 7) == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with a fetch already pending: no grant may leak out.
    rst_n = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 10'h005;
    #2;
    chk("reset_blocks_if_gnt", 32'(if_gnt), 0);
    chk("reset_mem_en", 32'(mem_en), 0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("first_fetch_gnt", 32'(if_gnt), 1);
    chk("first_fetch_mem_en", 32'(mem_en), 1);
    chk("first_fetch_addr", 32'(mem_addr), 32'h5);
    tick();
    if_req = 1'b0;
    #2;
    chk("first_fetch_rvalid", 32'(if_rvalid), 1);
    chk("first_fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("first_fetch_dm_rvalid", 32'(dm_rvalid), 0);

    // Store to 3FF then load it back.
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'h12345678;
    #2;
    chk("sw_gnt", 32'(dm_gnt), 1);
    chk("sw_mem_we", 32'(mem_we), 1);
    tick();
    dm_we = 1'b0;
    #2;
    chk("sw_no_rvalid", 32'(dm_rvalid), 0);
    chk("lw_gnt", 32'(dm_gnt), 1);
    chk("lw_mem_we", 32'(mem_we), 0);
    tick();
    dm_req = 1'b0;
    #2;
    chk("lw_rvalid", 32'(dm_rvalid), 1);
    chk("lw_rdata", dm_rdata, 32'h12345678);

    // Both ports held for 12 cycles from a clean reset.
    tick();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if_req = 1'b1; if_addr = ADDR_W'($urandom_range(0, 1023));
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = ADDR_W'($urandom_range(0, 1023));
      #2;
      chk("starve_if_gnt", 32'(if_gnt), 32'((i % 5) == 4));
      chk("starve_dm_gnt", 32'(dm_gnt), 32'((i % 5) != 4));
      tick();
    end
    idle_inputs();
    #2;
    chk("conflict_after_12", 32'(conflict_cnt), 32'd12);

    // Halt with fetch pending, DM idle.
    tick();
    halt = 1'b1; if_req = 1'b1; if_addr = 10'h010;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("halt_no_if_gnt", 32'(if_gnt), 0);
      tick();
    end
    halt = 1'b0;
    #2;
    chk("unhalt_if_gnt", 32'(if_gnt), 1);
    tick();
    if_req = 1'b0;

    // Halt while DM is busy: starvation must not accumulate during halt.
    tick();
    halt = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h020;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("halt_dm_gnt", 32'(dm_gnt), 1);
      tick();
    end
    halt = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #2;
      chk("post_halt_if_gnt", 32'(if_gnt), 32'(j == 4));
      tick();
    end
    idle_inputs();

    // Reset in the middle of a read-grant cycle.
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h007;
    #2;
    chk("midrst_gnt", 32'(dm_gnt), 1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("midrst_dm_gnt", 32'(dm_gnt), 0);
    chk("midrst_mem_en", 32'(mem_en), 0);
    chk("midrst_conflict", 32'(conflict_cnt), 0);
    dm_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    #2;
    chk("midrst_no_rvalid", 32'(dm_rvalid), 0);
    chk("midrst_conflict_after", 32'(conflict_cnt), 0);

    // Reset while read data is being returned.
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h009;
    tick();
    dm_req = 1'b0;
    #2;
    chk("rdrst_rvalid_before", 32'(dm_rvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("rdrst_rvalid_killed", 32'(dm_rvalid), 0);
    chk("rdrst_rdata_killed", dm_rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Conflict counter saturation.
    do_reset();
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h100; dm_wdata = 32'hCAFE0000;
    repeat (20) tick();
    idle_inputs();
    #2;
    chk("conflict_saturated", 32'(conflict_cnt), 32'(CNT_MAX));

    // Random traffic.
    drive_random(600);
    tick();
    idle_inputs();
    repeat (3) tick();
    #2;
    chk("if_queue_drained", 32'(if_exp_q.size()), 0);
    chk("dm_queue_drained", 32'(dm_exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
